// File: rtl/dcache_tag_array.sv
// N-way set-associative tag store for the data cache: pipelined lookup with hit
// and victim selection, per-set round-robin replacement, hardware clear sweep.
module dcache_tag_array #(
  parameter int  NUM_WAYS       = 4,
  parameter int  SET_ADDR_WIDTH = 9,
  parameter int  TAG_WIDTH      = 19,
  localparam int WAY_W          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inv_all,
  output logic                      init_done,
  input  logic                      lkp_req,
  output logic                      lkp_ready,
  input  logic [SET_ADDR_WIDTH-1:0] lkp_set,
  input  logic [TAG_WIDTH-1:0]      lkp_tag,
  output logic                      rsp_valid,
  output logic                      rsp_hit,
  output logic [WAY_W-1:0]          rsp_way,
  output logic                      rsp_dirty,
  output logic [WAY_W-1:0]          rsp_victim_way,
  output logic                      rsp_victim_valid,
  output logic                      rsp_victim_dirty,
  output logic [TAG_WIDTH-1:0]      rsp_victim_tag,
  input  logic                      upd_en,
  input  logic [SET_ADDR_WIDTH-1:0] upd_set,
  input  logic [WAY_W-1:0]          upd_way,
  input  logic [TAG_WIDTH-1:0]      upd_tag,
  input  logic                      upd_valid,
  input  logic                      upd_dirty,
  input  logic                      upd_fill
);
  localparam int NUM_SETS = 1 << SET_ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  state_e                    state_q, state_d;
  logic [SET_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]      lkp_tag_q, lkp_tag_d;
  entry_t                    rd_q [NUM_WAYS];
  entry_t                    rd_d [NUM_WAYS];
  logic [WAY_W-1:0]          rr_rd_q, rr_rd_d;

  logic                      lkp_fire, upd_fire;
  logic [NUM_WAYS-1:0]       wr_en;
  logic [SET_ADDR_WIDTH-1:0] wr_set;
  entry_t                    wr_data;
  logic                      rr_wr_en;
  logic [WAY_W-1:0]          rr_wr_data;
  entry_t                    mem_rd [NUM_WAYS];
  logic [WAY_W-1:0]          rr_mem [NUM_SETS];
  logic [WAY_W-1:0]          rr_mem_rd;

  // Write port: the clear sweep owns the RAMs in INIT, controller updates in READY.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    lkp_fire      = lkp_req && (state_q == ST_READY);
    upd_fire      = upd_en && (state_q == ST_READY) && !rst &&
                    ({1'b0, upd_way} < (WAY_W+1)'(NUM_WAYS));
    wr_en         = '0;
    wr_set        = upd_set;
    wr_data.valid = upd_valid;
    wr_data.dirty = upd_dirty;
    wr_data.tag   = upd_tag;
    rr_wr_en      = upd_fire && upd_fill && upd_valid;
    rr_wr_data    = ({1'b0, upd_way} == (WAY_W+1)'(NUM_WAYS-1)) ? '0 : upd_way + WAY_W'(1);
    if (state_q == ST_INIT) begin
      wr_en      = {NUM_WAYS{!rst}};
      wr_set     = cnt_q;
      wr_data    = '0;
      rr_wr_en   = !rst;
      rr_wr_data = '0;
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) wr_en[w] = upd_fire && (upd_way == WAY_W'(w));
    end
  end

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    entry_t mem [NUM_SETS];
    // NOTE: RAM contents have no reset; the INIT sweep clears them so each way maps onto a plain SDP macro.
    always_ff @(posedge clk) begin
      if (wr_en[g]) mem[wr_set] <= wr_data;
    end
    assign mem_rd[g] = mem[lkp_set];
  end

  always_ff @(posedge clk) begin
    if (rr_wr_en) rr_mem[wr_set] <= rr_wr_data;
  end
  assign rr_mem_rd = rr_mem[lkp_set];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = lkp_fire;
    lkp_tag_d   = lkp_tag_q;
    rd_d        = rd_q;
    rr_rd_d     = rr_rd_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + SET_ADDR_WIDTH'(1);
      if (inv_all)          cnt_d   = '0;
      else if (cnt_q == '1) state_d = ST_READY;
    end else if (inv_all) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
    // Same-cycle update to the looked-up set is forwarded into the read registers.
    if (lkp_fire) begin
      lkp_tag_d = lkp_tag;
      for (int w = 0; w < NUM_WAYS; w++)
        rd_d[w] = (wr_en[w] && (wr_set == lkp_set)) ? wr_data : mem_rd[w];
      rr_rd_d = (rr_wr_en && (wr_set == lkp_set)) ? rr_wr_data : rr_mem_rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      lkp_tag_q   <= '0;
      rr_rd_q     <= '0;
      for (int w = 0; w < NUM_WAYS; w++) rd_q[w] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      lkp_tag_q   <= lkp_tag_d;
      rr_rd_q     <= rr_rd_d;
      rd_q        <= rd_d;
    end
  end

  logic             hit, hit_dirty;
  logic [WAY_W-1:0] hit_way, vic_way;
  entry_t           vic;

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_dirty = 1'b0;
    vic_way   = rr_rd_q;
    vic       = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_q[w].valid && (rd_q[w].tag == lkp_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!rd_q[w].valid) vic_way = WAY_W'(w);
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_way == WAY_W'(w)) hit_dirty = rd_q[w].dirty;
      if (vic_way == WAY_W'(w)) vic = rd_q[w];
    end
  end

  assign init_done        = (state_q == ST_READY);
  assign lkp_ready        = init_done;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = hit;
  assign rsp_way          = hit_way;
  assign rsp_dirty        = hit && hit_dirty;
  assign rsp_victim_way   = vic_way;
  assign rsp_victim_valid = vic.valid;
  assign rsp_victim_dirty = vic.dirty;
  assign rsp_victim_tag   = vic.tag;

endmodule

// File: doc/dcache_tag_array.md
Name: dcache_tag_array

Overview:
- Parametrised N-way set-associative tag store for the data cache. Successor to the fixed 512x21 single-way tag RAM.
- Per way and per set it holds a tag, a valid bit and a dirty bit, plus one round-robin replacement pointer per set.
- It performs single-cycle pipelined lookups with hit detection and victim selection, and it clears itself by hardware sweep after reset or on flush.
- It sits between the cache controller FSM and per-way simple dual-port RAM macros.

Parameters:
- NUM_WAYS, 4, number of ways; power of two, 1..8.
- SET_ADDR_WIDTH, 9, set index width; depth is 2^SET_ADDR_WIDTH sets.
- TAG_WIDTH, 19, stored tag width; each entry is TAG_WIDTH+2 bits.
- WAY_W (derived, not overridable) = max(1, log2(NUM_WAYS)).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous active-high reset.
- inv_all  in  1  invalidate all entries by restarting the clear sweep.
- init_done  out  1  high when the sweep is finished and the array is usable.
- lkp_req  in  1  lookup request.
- lkp_ready  out  1  lookup accepted when lkp_req & lkp_ready; equals init_done.
- lkp_set  in  SET_ADDR_WIDTH  lookup set index.
- lkp_tag  in  TAG_WIDTH  lookup tag.
- rsp_valid  out  1  lookup result valid, one cycle.
- rsp_hit  out  1  tag match in a valid way.
- rsp_way  out  WAY_W  hit way.
- rsp_dirty  out  1  dirty bit of the hit way.
- rsp_victim_way  out  WAY_W  replacement candidate.
- rsp_victim_valid  out  1  victim way currently valid.
- rsp_victim_dirty  out  1  victim needs writeback.
- rsp_victim_tag  out  TAG_WIDTH  victim tag, used for the writeback address.
- upd_en  in  1  entry write.
- upd_set  in  SET_ADDR_WIDTH  set to write.
- upd_way  in  WAY_W  way to write.
- upd_tag  in  TAG_WIDTH  tag to write.
- upd_valid  in  1  valid bit to write.
- upd_dirty  in  1  dirty bit to write.
- upd_fill  in  1  update is a line fill; advances the replacement pointer.

Behaviour:
- States: INIT and READY.
- Reset:
  - rst=1 at an edge gives state INIT and sweep counter 0.
  - All rsp_* outputs go to 0, init_done=0.
  - rst overrides every other input, including in mid-sweep or mid-lookup.
- INIT sweep:
  - Each cycle writes {tag=0, valid=0, dirty=0} to every way of set counter, clears rr_ptr[counter], then increments the counter.
  - After set 2^S-1 is written, the state moves to READY; init_done=1 from the following cycle.
  - The sweep lasts 2^SET_ADDR_WIDTH cycles (512 at default).
  - lkp_ready=0 during INIT. lkp_req is dropped; the requester holds it.
  - upd_en is ignored during INIT.
- inv_all:
  - In READY: the state moves to INIT with counter 0 and init_done drops the next cycle.
  - A lookup accepted in the same cycle still produces its rsp_valid.
  - In INIT: the counter restarts at 0.
- Lookup:
  - Accepted in cycle N gives rsp_valid=1 in cycle N+1 for exactly one cycle.
  - Fully pipelined: one lookup per cycle, back-to-back.
  - rsp_* hold their last values when rsp_valid=0.
- Hit:
  - rsp_hit = OR over ways of (valid & tag==lkp_tag).
  - rsp_way = lowest matching index, or 0 on miss.
  - Multiple matches are a controller error; the lowest index still wins.
- Victim:
  - The lowest-index invalid way is chosen.
  - If all ways are valid, rr_ptr[set] is chosen.
  - rsp_victim_valid, rsp_victim_dirty and rsp_victim_tag come from that way.
  - NUM_WAYS=1: the victim is always way 0.
- Update:
  - Written at the edge of the cycle upd_en=1; only entry [upd_set][upd_way] changes.
  - If upd_fill & upd_valid & upd_en, then rr_ptr[upd_set] <= (upd_way+1) mod NUM_WAYS, wrapping to 0 after the last way.
- Collision, same cycle:
  - Lookup accepted in cycle N and upd_en in cycle N to the same set: the response reflects post-update contents (write-first bypass), including the new rr_ptr.
  - Different set: no interaction.
- Collision, next cycle: an update in cycle N+1 to the set of the response leaves that response unchanged.
- Storage: one synchronous-read array per way (TAG_WIDTH+2 bits x 2^S) plus an rr_ptr array. The bypass is done in registers, not RAM read-during-write.

Test Plan:
- Reset sweep: pulse rst, then hold lkp_req with set 0x1FF. Expect init_done rising exactly 512 cycles after rst falls, lkp_ready=0 until then, and the first response rsp_hit=0, rsp_victim_way=0, rsp_victim_valid=0.
- Fill then hit:
  - Fill (fill=1) set 5 way 2 with tag 0x1ABCD, valid=1, dirty=1.
  - Lookup set 5 tag 0x1ABCD the next cycle: expect rsp_hit=1, rsp_way=2, rsp_dirty=1.
  - Lookup with tag 0x1ABCE: expect rsp_hit=0.
- Replacement:
  - Fill ways 0..3 of set 7 in order, all with fill=1.
  - Lookup a miss: expect victim_way=0 (pointer wrapped after way 3), victim_valid=1.
  - Refill way 0, then miss again: expect victim_way=1.
- Bypass: in the same cycle, lookup set 9 tag 0x00042 and update set 9 way 1 tag 0x00042 valid=1. Expect rsp_hit=1, rsp_way=1 at N+1.
- Flush mid-stream: issue back-to-back lookups and assert inv_all on the cycle of the third. Expect three rsp_valid pulses, init_done=0 for 512 cycles, and all ways invalid afterwards.
- rst at sweep count 100: expect the counter restarted and init_done exactly 512 cycles after rst is released.
